// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side byte handshake shared by NUM_REQ producers
//   req_valid : per-requester byte valid
//   req_last  : per-requester end-of-packet flag for the presented byte
//   req_data  : packed bytes, requester i at [i*DATA_W +: DATA_W]
//   req_ready : one-hot accept strobe back to the requesters
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    modport master (output req_valid, req_last, req_data, input req_ready);
    modport slave  (input req_valid, req_last, req_data, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one UART transmit path
//   CLK, reset   : clock, synchronous active-high reset
//   req          : requester handshake (valid/last/data in, one-hot ready out)
//   byte_ready   : a byte is pending for the transmit controller
//   tx_byte      : load the shift register now
//   tx_data      : registered byte for the shift register
//   busy_tx      : transmit controller busy
//   grant_id     : current or last owner
//   locked       : a packet is in progress
//   err_timeout  : one-cycle pulse when a byte is aborted
module uart_tx_arbiter #(
    parameter int  NUM_REQ      = 3,
    parameter int  DATA_W       = 8,
    parameter int  BUSY_TIMEOUT = 15,
    localparam int IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic              CLK,
    input  logic              reset,
    uart_tx_arbiter_if.slave  req,
    output logic              byte_ready,
    output logic              tx_byte,
    output logic [DATA_W-1:0] tx_data,
    input  logic              busy_tx,
    output logic [IW-1:0]     grant_id,
    output logic              locked,
    output logic              err_timeout
);
    localparam int            CW      = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BUSY_TIMEOUT);
    localparam logic [CW-1:0] CNT_END = CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] last_grant, win, cand;
    logic [CW-1:0] cnt;
    logic          last_flag, issue_q, found, grant, timeout;

    // A locked packet only lets its owner back in; otherwise scan from last_grant+1.
    always_comb begin
        win   = grant_id;
        cand  = '0;
        found = locked ? req.req_valid[grant_id] : 1'b0;
        if (!locked)
            for (int i = 1; i <= NUM_REQ; i++) begin
                cand = IW'((int'(last_grant) + i) % NUM_REQ);
                if (!found && req.req_valid[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
    end

    assign grant   = state == IDLE && !busy_tx && !reset && found;
    // The counter reaches BUSY_TIMEOUT on this edge, so the byte is dropped now.
    assign timeout = state == ISSUE && !busy_tx && cnt == CNT_END;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= IDLE;
            issue_q    <= 1'b0;
            tx_data    <= '0;
            grant_id   <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            last_flag  <= 1'b0;
            locked     <= 1'b0;
            cnt        <= '0;
        end else begin
            state   <= state_nxt;
            issue_q <= state_nxt == ISSUE;
            if (grant) begin
                tx_data    <= req.req_data[win*DATA_W +: DATA_W];
                grant_id   <= win;
                last_grant <= win;
                last_flag  <= req.req_last[win];
                locked     <= 1'b1;
                cnt        <= '0;
            end
            if (state == ISSUE && !busy_tx)
                cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            if (timeout || (state == DONE && !busy_tx && last_flag))
                locked <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant ? ISSUE : IDLE;
            ISSUE:   state_nxt = busy_tx ? DONE : (timeout ? IDLE : ISSUE);
            DONE:    state_nxt = busy_tx ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req.req_ready = grant ? (NUM_REQ'(1) << win) : '0;
        byte_ready    = issue_q;
        tx_byte       = issue_q;
        err_timeout   = timeout;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 8;
    localparam int FRAME   = 4;

    logic              CLK      = 1'b0;
    logic              reset    = 1'b1;
    logic              busy_tx  = 1'b0;
    logic              model_en = 1'b0;
    logic              byte_ready, tx_byte, locked, err_timeout;
    logic [DATA_W-1:0] tx_data;
    logic [1:0]        grant_id;
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [8:0]        rq [NUM_REQ][$];
    int                glog[$];
    logic [7:0]        txlog[$];
    logic [NUM_REQ-1:0] acc = '0;
    logic              tx_prev = 1'b0;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) rif ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BUSY_TIMEOUT(15)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .req         (rif),
        .byte_ready  (byte_ready),
        .tx_byte     (tx_byte),
        .tx_data     (tx_data),
        .busy_tx     (busy_tx),
        .grant_id    (grant_id),
        .locked      (locked),
        .err_timeout (err_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back({l, d});
    endtask

    task automatic flush();
        for (int r = 0; r < NUM_REQ; r++) rq[r].delete();
    endtask

    task automatic clear_logs();
        glog.delete();
        txlog.delete();
    endtask

    task automatic reset_dut();
        @(posedge CLK);
        #1 reset = 1'b1;
        busy_tx = 1'b0;
        flush();
        repeat (2) @(posedge CLK);
        #1 reset = 1'b0;
    endtask

    task automatic wait_ready(input int max);
        for (int i = 0; i < max && rif.req_ready == '0; i++) @(negedge CLK);
    endtask

    task automatic wait_grants(input int n, input int max);
        int i;
        for (i = 0; i < max && glog.size() < n; i++) @(negedge CLK);
        check("grant wait", glog.size() >= n, 1);
    endtask

    task automatic drain(input int max);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge CLK);
            if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && !locked &&
                !busy_tx && !byte_ready && rif.req_valid == '0) break;
        end
        check("drain", i < max, 1);
    endtask

    function automatic int glog_at(input int i);
        return i < glog.size() ? glog[i] : -1;
    endfunction

    function automatic int txlog_at(input int i);
        return i < txlog.size() ? int'(txlog[i]) : -1;
    endfunction

    // Requesters: present queue heads, pop on accept, and log grants and loaded bytes.
    initial begin
        rif.req_valid = '0;
        rif.req_last  = '0;
        rif.req_data  = '0;
        forever begin
            @(posedge CLK);
            #1;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (acc[r] && rq[r].size() > 0) void'(rq[r].pop_front());
                rif.req_valid[r] = rq[r].size() > 0;
                rif.req_last[r]  = rq[r].size() > 0 ? rq[r][0][8] : 1'b0;
                rif.req_data[r*DATA_W +: DATA_W] = rq[r].size() > 0 ? rq[r][0][7:0] : 8'h00;
            end
            @(negedge CLK);
            acc = rif.req_valid & rif.req_ready;
            for (int r = 0; r < NUM_REQ; r++) if (acc[r]) glog.push_back(r);
            if (tx_byte && !tx_prev) txlog.push_back(tx_data);
            tx_prev = tx_byte;
        end
    end

    // Transmit controller: busy rises one cycle after the load and lasts FRAME cycles.
    initial begin
        forever begin
            @(negedge CLK);
            if (model_en && tx_byte && !busy_tx) begin
                @(posedge CLK);
                #1 busy_tx = 1'b1;
                repeat (FRAME) @(posedge CLK);
                #1 busy_tx = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]         exp2 [6];
        logic [7:0]         exp3 [5];
        int                 ord3 [5];
        int                 pulses, at;
        logic [NUM_REQ-1:0] seen;
        exp2 = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30};
        exp3 = '{8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1};
        ord3 = '{1, 1, 1, 0, 0};

        // Reset state and a single one-byte packet with a hand-driven busy_tx.
        reset_dut();
        @(negedge CLK);
        check("rst req_ready", rif.req_ready, 0);
        check("rst byte_ready", byte_ready, 0);
        check("rst tx_byte", tx_byte, 0);
        check("rst tx_data", tx_data, 0);
        check("rst grant_id", grant_id, 0);
        check("rst locked", locked, 0);
        check("rst err_timeout", err_timeout, 0);
        push(0, 8'h41, 1'b1);
        wait_ready(5);
        check("t1 ready", rif.req_ready, 3'b001);
        @(negedge CLK);
        check("t1 ready pulse", rif.req_ready, 0);
        check("t1 byte_ready", byte_ready, 1);
        check("t1 tx_byte", tx_byte, 1);
        check("t1 tx_data", tx_data, 8'h41);
        check("t1 locked", locked, 1);
        repeat (3) @(negedge CLK);
        check("t1 byte_ready held", byte_ready, 1);
        @(posedge CLK);
        #1 busy_tx = 1'b1;
        @(negedge CLK);
        check("t1 tx_byte before busy sampled", tx_byte, 1);
        @(negedge CLK);
        check("t1 byte_ready dropped", byte_ready, 0);
        check("t1 tx_byte dropped", tx_byte, 0);
        check("t1 locked in done", locked, 1);
        @(posedge CLK);
        #1 busy_tx = 1'b0;
        @(negedge CLK);
        check("t1 still locked", locked, 1);
        @(negedge CLK);
        check("t1 unlocked", locked, 0);
        check("t1 tx_data stable", tx_data, 8'h41);

        // All three valid, single-byte packets: rotation 0,1,2,0,1,2.
        reset_dut();
        model_en = 1'b1;
        clear_logs();
        for (int k = 0; k < 2; k++) begin
            push(0, 8'h10, 1'b1);
            push(1, 8'h20, 1'b1);
            push(2, 8'h30, 1'b1);
        end
        drain(400);
        check("t2 grant count", glog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2 grant %0d", i), glog_at(i), i % 3);
            check($sformatf("t2 tx_data %0d", i), txlog_at(i), exp2[i]);
        end
        check("t2 grant_id", grant_id, 2);

        // Three-byte packet from requester 1 is not interleaved with requester 0.
        clear_logs();
        push(1, 8'hA1, 1'b0);
        push(1, 8'hA2, 1'b0);
        push(1, 8'hA3, 1'b1);
        wait_grants(1, 50);
        push(0, 8'hB0, 1'b1);
        push(0, 8'hB1, 1'b1);
        drain(400);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3 grant %0d", i), glog_at(i), ord3[i]);
            check($sformatf("t3 tx_data %0d", i), txlog_at(i), exp3[i]);
        end

        // busy_tx never rises: abort on the 15th ISSUE cycle.
        model_en = 1'b0;
        push(2, 8'h55, 1'b1);
        wait_ready(10);
        check("t4 ready", rif.req_ready, 3'b100);
        pulses = 0;
        at = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (err_timeout) begin
                pulses++;
                if (at == 0) at = k;
            end
        end
        check("t4 pulses", pulses, 1);
        check("t4 pulse cycle", at, 15);
        check("t4 unlocked", locked, 0);
        check("t4 byte_ready", byte_ready, 0);
        model_en = 1'b1;
        clear_logs();
        push(0, 8'h66, 1'b1);
        drain(100);
        check("t4 next grant", glog_at(0), 0);
        check("t4 next tx_data", txlog_at(0), 8'h66);

        // Reset while locked in DONE.
        model_en = 1'b0;
        push(1, 8'h77, 1'b0);
        wait_ready(10);
        @(negedge CLK);
        @(posedge CLK);
        #1 busy_tx = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("t5 locked in done", locked, 1);
        check("t5 byte_ready in done", byte_ready, 0);
        @(posedge CLK);
        #1 reset = 1'b1;
        busy_tx = 1'b0;
        flush();
        @(negedge CLK);
        @(negedge CLK);
        check("t5 req_ready", rif.req_ready, 0);
        check("t5 byte_ready", byte_ready, 0);
        check("t5 tx_byte", tx_byte, 0);
        check("t5 tx_data", tx_data, 0);
        check("t5 grant_id", grant_id, 0);
        check("t5 locked", locked, 0);
        check("t5 err_timeout", err_timeout, 0);
        @(posedge CLK);
        #1 reset = 1'b0;
        model_en = 1'b1;
        @(negedge CLK);
        clear_logs();
        push(0, 8'hC0, 1'b1);
        push(1, 8'hC1, 1'b1);
        push(2, 8'hC2, 1'b1);
        drain(200);
        for (int i = 0; i < 3; i++)
            check($sformatf("t5 grant %0d", i), glog_at(i), i);

        // Foreign busy_tx activity blocks granting until it falls.
        model_en = 1'b0;
        @(posedge CLK);
        #1 busy_tx = 1'b1;
        push(2, 8'h99, 1'b1);
        seen = '0;
        repeat (6) begin
            @(negedge CLK);
            seen |= rif.req_ready;
        end
        check("t6 no ready while busy", seen, 0);
        @(posedge CLK);
        #1 busy_tx = 1'b0;
        @(negedge CLK);
        check("t6 ready after busy", rif.req_ready, 3'b100);
        @(negedge CLK);
        check("t6 byte_ready", byte_ready, 1);
        check("t6 tx_data", tx_data, 8'h99);
        model_en = 1'b1;
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
